// File: rtl/gate_pkg.sv
// Op codes and evaluation helpers for the registered logic unit.
// Shared by the top-level eval logic and any reference models.
package gate_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  typedef struct packed {
    logic y;
    logic err;
  } red_t;

  function automatic logic gate_bit(
    input logic [OP_W-1:0] op,
    input logic            a,
    input logic            b
  );
    logic r;
    r = 1'b0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
    endcase
    return r;
  endfunction

  // NOT/PASS have no reduction meaning: flag them, force y low.
  function automatic red_t reduce_eval(
    input logic [OP_W-1:0] op,
    input logic            r_and,
    input logic            r_or,
    input logic            r_xor
  );
    red_t r;
    r = '0;
    unique case (op)
      OP_AND:  r.y = r_and;
      OP_OR:   r.y = r_or;
      OP_NAND: r.y = ~r_and;
      OP_NOR:  r.y = ~r_or;
      OP_XOR:  r.y = r_xor;
      OP_XNOR: r.y = ~r_xor;
      OP_NOT:  r.err = 1'b1;
      OP_PASS: r.err = 1'b1;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/gate_pipe_skid.sv
// Valid/ready output register backed by a 1-entry skid buffer.
// in_ready is a flop, so out_ready never reaches it combinationally.
module gate_pipe_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      // Skid and accept are exclusive: accept needs skid empty.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: rtl/logic_gate_pipe.sv
// WIDTH-bit bitwise/reduction logic unit, one-cycle registered,
// valid/ready on both sides, with a saturating accept counter.
module logic_gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_reduce,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_err,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] op_count
);
  logic [WIDTH-1:0]   y_d;
  logic               err_d;
  logic [WIDTH:0]     res_out;
  red_t               red;
  logic               accept;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    y_d   = '0;
    err_d = 1'b0;
    red   = reduce_eval(in_op, &in_a, |in_a, ^in_a);
    if (in_reduce) begin
      y_d[0] = red.y;
      err_d  = red.err;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        y_d[i] = gate_bit(in_op, in_a[i], in_b[i]);
    end
  end

  gate_pipe_skid #(.W(WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({err_d, y_d}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_out)
  );

  assign out_y    = res_out[WIDTH-1:0];
  assign out_err  = res_out[WIDTH];
  assign accept   = in_valid & in_ready;
  assign op_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = accept ? COUNT_W'(1) : '0;
    else if (accept && cnt_q != {COUNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
